// File: rtl/mem_port_arbiter_if.sv
// Requester (IF/MEM) and byte-wide RAM signals seen by mem_port_arbiter.
// Handshake: a request is held until its port shows status 2'b01 for one cycle.
interface mem_port_arbiter_if #(parameter int ADDR_W = 17);
  logic [1:0]        rw_MEM_i;
  logic [31:0]       addr_MEM_i;
  logic [3:0]        mask_MEM_i;
  logic [31:0]       wdata_MEM_i;
  logic [31:0]       rdata_MEM_o;
  logic [1:0]        status_MEM_o;
  logic              req_IF_i;
  logic [31:0]       addr_IF_i;
  logic [31:0]       rdata_IF_o;
  logic [1:0]        status_IF_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic              ram_wr_o;
  logic [7:0]        ram_dout_o;
  logic [7:0]        ram_din_i;

  modport slave (
    input  rw_MEM_i, addr_MEM_i, mask_MEM_i, wdata_MEM_i, req_IF_i, addr_IF_i, ram_din_i,
    output rdata_MEM_o, status_MEM_o, rdata_IF_o, status_IF_o, ram_addr_o, ram_wr_o, ram_dout_o
  );

  modport master (
    output rw_MEM_i, addr_MEM_i, mask_MEM_i, wdata_MEM_i, req_IF_i, addr_IF_i, ram_din_i,
    input  rdata_MEM_o, status_MEM_o, rdata_IF_o, status_IF_o, ram_addr_o, ram_wr_o, ram_dout_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide synchronous RAM between IF fetch and MEM load/store ports.
// Optional macro ARB_ROUND_ROBIN_EN: ties go to the port not granted last.
module mem_port_arbiter #(
  parameter int ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_port_arbiter_if.slave     bus,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;

  state_t            state_q, state_d;
  logic              sel_mem_q;
  logic [2:0]        nbytes_q, cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, buf_q, rdata_mem_q, rdata_if_q;
  logic              mem_req, grant_mem, grant_if, req_read;
  logic [2:0]        mask_n, req_n;
  logic [31:0]       cap_data, wr_shift;
  logic              unused_addr_hi;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_mem_q;
`endif

  assign unused_addr_hi = ^{bus.addr_MEM_i[31:ADDR_W], bus.addr_IF_i[31:ADDR_W]};

  always_comb begin
    mem_req = (bus.rw_MEM_i != 2'b00);
`ifdef ARB_ROUND_ROBIN_EN
    grant_mem = mem_req && (!bus.req_IF_i || !last_mem_q);
`else
    grant_mem = mem_req;
`endif
    grant_if = bus.req_IF_i && !grant_mem;
    casez (bus.mask_MEM_i)
      4'b1???: mask_n = 3'd4;
      4'b01??: mask_n = 3'd3;
      4'b001?: mask_n = 3'd2;
      4'b0001: mask_n = 3'd1;
      default: mask_n = 3'd0;
    endcase
    req_n    = grant_mem ? mask_n : 3'd4;
    req_read = grant_mem ? bus.rw_MEM_i[1] : 1'b1;
  end

  // RAM data lags its address by one cycle, so byte cnt-1 arrives while cnt is current.
  always_comb begin
    cap_data = buf_q | ({24'd0, bus.ram_din_i} << {cnt_q - 3'd1, 3'b000});
    wr_shift = wdata_q >> {cnt_q[1:0], 3'b000};
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_mem || grant_if) begin
          if (req_n == 3'd0) state_d = DONE;
          else if (req_read) state_d = READ;
          else               state_d = WRITE;
        end
      end
      READ:    if (cnt_q == nbytes_q) state_d = DONE;
      WRITE:   if (cnt_q == nbytes_q - 3'd1) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ram_wr_o     = (state_q == WRITE);
    bus.ram_dout_o   = (state_q == WRITE) ? wr_shift[7:0] : 8'd0;
    bus.status_MEM_o = {1'b0, (state_q == DONE) && sel_mem_q};
    bus.status_IF_o  = {1'b0, (state_q == DONE) && !sel_mem_q};
    bus.ram_addr_o   = addr_q;
    bus.rdata_MEM_o  = rdata_mem_q;
    bus.rdata_IF_o   = rdata_if_q;
    dbg_state        = state_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sel_mem_q   <= 1'b0;
      nbytes_q    <= 3'd0;
      cnt_q       <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      buf_q       <= 32'd0;
      rdata_mem_q <= 32'd0;
      rdata_if_q  <= 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
      last_mem_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_mem || grant_if) begin
            sel_mem_q <= grant_mem;
            nbytes_q  <= req_n;
            cnt_q     <= 3'd0;
            buf_q     <= 32'd0;
            wdata_q   <= bus.wdata_MEM_i;
`ifdef ARB_ROUND_ROBIN_EN
            last_mem_q <= grant_mem;
`endif
            // A zero-length access never touches the RAM, so the address bus keeps its value.
            if (req_n != 3'd0)
              addr_q <= grant_mem ? bus.addr_MEM_i[ADDR_W-1:0] : bus.addr_IF_i[ADDR_W-1:0];
            else if (grant_mem && req_read)
              rdata_mem_q <= 32'd0;
          end
        end
        READ: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q + 3'd1 < nbytes_q) addr_q <= addr_q + ADDR_W'(1);
          if (cnt_q != 3'd0) begin
            if (cnt_q == nbytes_q) begin
              if (sel_mem_q) rdata_mem_q <= cap_data;
              else           rdata_if_q  <= cap_data;
            end else begin
              buf_q <= cap_data;
            end
          end
        end
        WRITE: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q + 3'd1 < nbytes_q) addr_q <= addr_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a synchronous byte RAM model.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 17;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] dbg_state;
  int         tests_run = 0;
  int         tests_failed = 0;

  logic [7:0]  ram [0:(1<<ADDR_W)-1];
  logic [31:0] addr_log [16];
  logic [31:0] wr_log   [16];
  logic [31:0] dout_log [16];
  logic [31:0] stm_log  [16];
  logic [31:0] sti_log  [16];
  logic [31:0] rdm_log  [16];
  logic [31:0] rdi_log  [16];
  logic [1:0]  exp_q [$];

  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data appears the cycle after its address.
  always @(posedge clk) begin
    bus.ram_din_i <= ram[bus.ram_addr_o];
    if (bus.ram_wr_o) ram[bus.ram_addr_o] = bus.ram_dout_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue_mem(input logic [1:0] rw, input logic [31:0] addr,
                           input logic [3:0] mask, input logic [31:0] wdata);
    @(negedge clk);
    bus.rw_MEM_i = rw; bus.addr_MEM_i = addr; bus.mask_MEM_i = mask; bus.wdata_MEM_i = wdata;
  endtask

  task automatic issue_if(input logic [31:0] addr);
    @(negedge clk);
    bus.req_IF_i = 1'b1; bus.addr_IF_i = addr;
  endtask

  // Logs cycles 1..n after the grant edge; MEM request drops in cycle 1, IF in cycle if_drop.
  task automatic record(input int n, input int if_drop);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      addr_log[c] = 32'(bus.ram_addr_o);
      wr_log[c]   = 32'(bus.ram_wr_o);
      dout_log[c] = 32'(bus.ram_dout_o);
      stm_log[c]  = 32'(bus.status_MEM_o);
      sti_log[c]  = 32'(bus.status_IF_o);
      rdm_log[c]  = bus.rdata_MEM_o;
      rdi_log[c]  = bus.rdata_IF_o;
      if (c == 1) bus.rw_MEM_i = 2'b00;
      if (c == if_drop) bus.req_IF_i = 1'b0;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_addr"},  32'(bus.ram_addr_o), 32'd0);
    check({tag, "_wr"},    32'(bus.ram_wr_o), 32'd0);
    check({tag, "_dout"},  32'(bus.ram_dout_o), 32'd0);
    check({tag, "_stm"},   32'(bus.status_MEM_o), 32'd0);
    check({tag, "_sti"},   32'(bus.status_IF_o), 32'd0);
    check({tag, "_rdm"},   bus.rdata_MEM_o, 32'd0);
    check({tag, "_rdi"},   bus.rdata_IF_o, 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    logic [1:0] got;
    int         budget;
    for (int a = 0; a < (1 << ADDR_W); a++) ram[a] = 8'h00;
    bus.ram_din_i = 8'h00;
    bus.rw_MEM_i = 2'b00; bus.addr_MEM_i = 32'd0; bus.mask_MEM_i = 4'd0; bus.wdata_MEM_i = 32'd0;
    bus.req_IF_i = 1'b0;  bus.addr_IF_i = 32'd0;
    ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
    ram[32'h200] = 8'hAA; ram[32'h201] = 8'hAA; ram[32'h202] = 8'hAA;
    ram[32'h10]  = 8'h80;
    ram[0] = 8'h13; ram[1] = 8'h05; ram[2] = 8'h00; ram[3] = 8'h00;
    ram[4] = 8'h93; ram[5] = 8'h00; ram[6] = 8'h10; ram[7] = 8'h00;
    ram[17'h1FFFE] = 8'hA1; ram[17'h1FFFF] = 8'hB2;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b1;

    // MEM word read
    issue_mem(2'b10, 32'h100, 4'b1111, 32'd0);
    record(7, 1);
    for (int c = 1; c <= 4; c++) check("rdw_addr", addr_log[c], 32'h100 + 32'(c - 1));
    for (int c = 1; c <= 7; c++) begin
      check("rdw_stm", stm_log[c], (c == 6) ? 32'd1 : 32'd0);
      check("rdw_wr", wr_log[c], 32'd0);
      check("rdw_sti", sti_log[c], 32'd0);
    end
    check("rdw_data", rdm_log[6], 32'h44332211);
    check("rdw_hold", rdm_log[7], 32'h44332211);

    // MEM store half
    issue_mem(2'b01, 32'h200, 4'b0011, 32'hDEADBEEF);
    record(4, 1);
    check("sh_wr1", wr_log[1], 32'd1);
    check("sh_addr1", addr_log[1], 32'h200);
    check("sh_dout1", dout_log[1], 32'hEF);
    check("sh_wr2", wr_log[2], 32'd1);
    check("sh_addr2", addr_log[2], 32'h201);
    check("sh_dout2", dout_log[2], 32'hBE);
    check("sh_wr3", wr_log[3], 32'd0);
    check("sh_addr3", addr_log[3], 32'h201);
    check("sh_stm3", stm_log[3], 32'd1);
    check("sh_stm2", stm_log[2], 32'd0);
    check("sh_stm4", stm_log[4], 32'd0);
    check("sh_ram200", 32'(ram[32'h200]), 32'hEF);
    check("sh_ram201", 32'(ram[32'h201]), 32'hBE);
    check("sh_ram202", 32'(ram[32'h202]), 32'hAA);

    // Contention: MEM lb and IF fetch in the same cycle
    @(negedge clk);
    bus.rw_MEM_i = 2'b10; bus.addr_MEM_i = 32'h10; bus.mask_MEM_i = 4'b0001;
    bus.req_IF_i = 1'b1;  bus.addr_IF_i = 32'h0;
    record(11, 10);
    check("ct_mem_addr", addr_log[1], 32'h10);
    check("ct_stm3", stm_log[3], 32'd1);
    check("ct_rdm3", rdm_log[3], 32'h00000080);
    for (int c = 1; c <= 9; c++) check("ct_sti_quiet", sti_log[c], 32'd0);
    check("ct_if_addr0", addr_log[5], 32'h0);
    check("ct_if_addr3", addr_log[8], 32'h3);
    check("ct_sti10", sti_log[10], 32'd1);
    check("ct_stm10", stm_log[10], 32'd0);
    check("ct_rdi10", rdi_log[10], 32'h00000513);
    check("ct_sti11", sti_log[11], 32'd0);

    // Reset in cycle 3 of a word read
    issue_mem(2'b10, 32'h100, 4'b1111, 32'd0);
    @(negedge clk); bus.rw_MEM_i = 2'b00;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("midrst");
    rst = 1'b1;
    for (int c = 5; c <= 8; c++) begin
      @(negedge clk);
      check("midrst_nodone", 32'(bus.status_MEM_o), 32'd0);
    end
    issue_if(32'h4);
    record(7, 1);
    check("if_addr1", addr_log[1], 32'h4);
    check("if_addr4", addr_log[4], 32'h7);
    check("if_sti5", sti_log[5], 32'd0);
    check("if_sti6", sti_log[6], 32'd1);
    check("if_sti7", sti_log[7], 32'd0);
    check("if_stm6", stm_log[6], 32'd0);
    check("if_rdi6", rdi_log[6], 32'h00100093);

    // Word read wrapping past the top of the RAM
    issue_mem(2'b10, 32'h0001FFFE, 4'b1111, 32'd0);
    record(7, 1);
    check("wrap_a1", addr_log[1], 32'h1FFFE);
    check("wrap_a2", addr_log[2], 32'h1FFFF);
    check("wrap_a3", addr_log[3], 32'h00000);
    check("wrap_a4", addr_log[4], 32'h00001);
    check("wrap_stm6", stm_log[6], 32'd1);
    check("wrap_data", rdm_log[6], 32'h0513B2A1);

    // Zero mask: immediate done, zero data, address bus untouched
    issue_mem(2'b10, 32'h300, 4'b0000, 32'd0);
    record(3, 1);
    check("z_stm1", stm_log[1], 32'd1);
    check("z_rdm1", rdm_log[1], 32'd0);
    check("z_wr1", wr_log[1], 32'd0);
    check("z_addr1", addr_log[1], 32'h1);
    check("z_stm2", stm_log[2], 32'd0);

    // Both ports held active: grant sequence depends on arbitration mode
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
`else
    exp_q.push_back(2'd1); exp_q.push_back(2'd1); exp_q.push_back(2'd1); exp_q.push_back(2'd1);
`endif
    @(negedge clk);
    bus.rw_MEM_i = 2'b10; bus.addr_MEM_i = 32'h10; bus.mask_MEM_i = 4'b0001;
    bus.req_IF_i = 1'b1;  bus.addr_IF_i = 32'h0;
    budget = 80;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
      if (bus.status_MEM_o[0] || bus.status_IF_o[0]) begin
        check("arb_excl", 32'(bus.status_MEM_o[0] & bus.status_IF_o[0]), 32'd0);
        got = bus.status_MEM_o[0] ? 2'd1 : 2'd2;
        check("arb_grant", 32'(got), 32'(exp_q.pop_front()));
      end
    end
    bus.rw_MEM_i = 2'b00; bus.req_IF_i = 1'b0;
    if (exp_q.size() != 0) check("arb_timeout", 32'(exp_q.size()), 32'd0);
    repeat (10) @(negedge clk);
    check("final_state", 32'(dbg_state), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
